// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war playfield.
package tug_pkg;

  typedef enum logic [1:0] {
    StPlay      = 2'd0,
    StPoint     = 2'd1,
    StMatchOver = 2'd2
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b10;
  localparam logic [1:0] WIN_RIGHT = 2'b01;

endpackage

// File: rtl/tug_score_counter.sv
// Per-player score counter; saturates at WIN_SCORE and flags when it gets there.
module tug_score_counter #(
  parameter int unsigned WIN_SCORE = 7,
  localparam int unsigned SCORE_W  = $clog2(WIN_SCORE + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               ce_i,
  input  logic               inc_i,
  output logic [SCORE_W-1:0] count_o,
  output logic               at_max_o
);

  localparam logic [SCORE_W-1:0] ScoreMax = SCORE_W'(WIN_SCORE);

  logic [SCORE_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != ScoreMax)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (ce_i) begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign at_max_o = (count_q == ScoreMax);

endmodule

// File: rtl/tug_track.sv
// Tug-of-war playfield: one lit position pushed by two players, scoring, hold and match end.
module tug_track
  import tug_pkg::*;
#(
  parameter int unsigned NUM_LIGHTS = 9,
  parameter int unsigned WIN_SCORE  = 7,
  parameter int unsigned HOLD_TICKS = 4,
  localparam int unsigned SCORE_W   = $clog2(WIN_SCORE + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  ce_i,
  input  logic                  l_i,
  input  logic                  r_i,
  output logic [NUM_LIGHTS-1:0] lights_o,
  output logic [SCORE_W-1:0]    left_score_o,
  output logic [SCORE_W-1:0]    right_score_o,
  output logic [1:0]            winner_o,
  output logic                  match_over_o
);

  localparam int unsigned POS_W     = $clog2(NUM_LIGHTS);
  localparam int unsigned HOLD_W    = $clog2(HOLD_TICKS + 1);
  localparam int unsigned CentreIdx = NUM_LIGHTS / 2;

  localparam logic [POS_W-1:0]   PosMax    = POS_W'(NUM_LIGHTS - 1);
  localparam logic [POS_W-1:0]   PosCentre = POS_W'(CentreIdx);
  localparam logic [HOLD_W-1:0]  HoldLast  = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [SCORE_W-1:0] ScoreLast = SCORE_W'(WIN_SCORE - 1);

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               inc_left, inc_right;
  logic               left_at_max, right_at_max;

  tug_score_counter #(
    .WIN_SCORE (WIN_SCORE)
  ) u_left_score (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .ce_i     (ce_i),
    .inc_i    (inc_left),
    .count_o  (left_score_o),
    .at_max_o (left_at_max)
  );

  tug_score_counter #(
    .WIN_SCORE (WIN_SCORE)
  ) u_right_score (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .ce_i     (ce_i),
    .inc_i    (inc_right),
    .count_o  (right_score_o),
    .at_max_o (right_at_max)
  );

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    hold_d    = hold_q;
    inc_left  = 1'b0;
    inc_right = 1'b0;
    unique case (state_q)
      StPlay: begin
        if (l_i && !r_i) begin
          if (pos_q == PosMax) begin
            inc_left = 1'b1;
            hold_d   = '0;
            state_d  = (left_score_o == ScoreLast) ? StMatchOver : StPoint;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end else if (r_i && !l_i) begin
          if (pos_q == '0) begin
            inc_right = 1'b1;
            hold_d    = '0;
            state_d   = (right_score_o == ScoreLast) ? StMatchOver : StPoint;
          end else begin
            pos_d = pos_q - 1'b1;
          end
        end
      end
      StPoint: begin
        if (hold_q == HoldLast) begin
          state_d = StPlay;
          pos_d   = PosCentre;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StMatchOver: ;
      default: state_d = StPlay;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StPlay;
      pos_q   <= PosCentre;
      hold_q  <= '0;
    end else if (ce_i) begin
      state_q <= state_d;
      pos_q   <= pos_d;
      hold_q  <= hold_d;
    end
  end

  // Counters reach max on the same edge the FSM enters StMatchOver, so winner needs no register.
  always_comb begin
    winner_o = WIN_NONE;
    if (left_at_max) begin
      winner_o = WIN_LEFT;
    end else if (right_at_max) begin
      winner_o = WIN_RIGHT;
    end
  end

  assign match_over_o = (state_q == StMatchOver);

  always_comb begin
    lights_o = '0;
    unique case (state_q)
      StPlay: begin
        for (int unsigned i = 0; i < NUM_LIGHTS; i++) begin
          lights_o[i] = (pos_q == POS_W'(i));
        end
      end
      StMatchOver: begin
        for (int unsigned i = 0; i < NUM_LIGHTS; i++) begin
          lights_o[i] = left_at_max ? (i >= CentreIdx) : (i <= CentreIdx);
        end
      end
      default: lights_o = '0;
    endcase
  end

endmodule

// File: tb/tb_tug_track.sv
// Directed vector bench for tug_track at NUM_LIGHTS=5, WIN_SCORE=2, HOLD_TICKS=3.
module tb_tug_track;

  logic       clk = 1'b0;
  logic       reset, ce, l, r;
  logic [4:0] lights;
  logic [1:0] left_score, right_score, winner;
  logic       match_over;

  int checks   = 0;
  int failures = 0;

  tug_track #(
    .NUM_LIGHTS (5),
    .WIN_SCORE  (2),
    .HOLD_TICKS (3)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .ce_i          (ce),
    .l_i           (l),
    .r_i           (r),
    .lights_o      (lights),
    .left_score_o  (left_score),
    .right_score_o (right_score),
    .winner_o      (winner),
    .match_over_o  (match_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, ce, l, r;
    logic [4:0] lights;
    logic [1:0] ls, rs, win;
    logic       mo;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic rst_v, logic ce_v, logic l_v, logic r_v, logic [4:0] lt,
                              logic [1:0] ls, logic [1:0] rs, logic [1:0] win, logic mo);
    vec_t v;
    v.rst = rst_v; v.ce = ce_v; v.l = l_v; v.r = r_v;
    v.lights = lt; v.ls = ls; v.rs = rs; v.win = win; v.mo = mo;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic rst_v, input logic ce_v, input logic l_v, input logic r_v);
    @(negedge clk);
    reset = rst_v; ce = ce_v; l = l_v; r = r_v;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [4:0] lt, input logic [1:0] ls,
                       input logic [1:0] rs, input logic [1:0] win, input logic mo);
    logic [11:0] act, exp;
    act = {lights, left_score, right_score, winner, match_over};
    exp = {lt, ls, rs, win, mo};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got lights=%b ls=%0d rs=%0d win=%b mo=%b, want lights=%b ls=%0d rs=%0d win=%b mo=%b",
               name, lights, left_score, right_score, winner, match_over, lt, ls, rs, win, mo);
    end
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; l = 1'b0; r = 1'b0;

    //  rst ce  l  r   lights    ls rs win  mo
    add(1, 0, 0, 0, 5'b00100, 0, 0, 2'b00, 0);  // reset overrides CE=0
    add(0, 1, 1, 0, 5'b01000, 0, 0, 2'b00, 0);
    add(0, 1, 1, 0, 5'b10000, 0, 0, 2'b00, 0);
    add(0, 1, 1, 0, 5'b00000, 1, 0, 2'b00, 0);  // left point
    add(0, 1, 0, 0, 5'b00000, 1, 0, 2'b00, 0);
    add(0, 1, 0, 1, 5'b00000, 1, 0, 2'b00, 0);  // press ignored during hold
    add(0, 1, 0, 0, 5'b00100, 1, 0, 2'b00, 0);  // third blank tick ends
    add(0, 0, 1, 0, 5'b00100, 1, 0, 2'b00, 0);  // CE=0 holds
    add(0, 1, 1, 1, 5'b00100, 1, 0, 2'b00, 0);  // both pressed
    add(0, 1, 0, 1, 5'b00010, 1, 0, 2'b00, 0);
    add(0, 1, 0, 1, 5'b00001, 1, 0, 2'b00, 0);
    add(0, 1, 0, 1, 5'b00000, 1, 1, 2'b00, 0);  // right point
    add(0, 1, 1, 0, 5'b00000, 1, 1, 2'b00, 0);
    add(0, 1, 1, 0, 5'b00000, 1, 1, 2'b00, 0);
    add(0, 1, 1, 0, 5'b00100, 1, 1, 2'b00, 0);
    add(0, 1, 1, 0, 5'b01000, 1, 1, 2'b00, 0);
    add(0, 1, 1, 0, 5'b10000, 1, 1, 2'b00, 0);
    add(0, 1, 1, 0, 5'b11100, 2, 1, 2'b10, 1);  // left wins
    add(0, 1, 0, 1, 5'b11100, 2, 1, 2'b10, 1);
    add(0, 1, 1, 0, 5'b11100, 2, 1, 2'b10, 1);
    add(0, 1, 0, 1, 5'b11100, 2, 1, 2'b10, 1);
    add(1, 0, 0, 0, 5'b00100, 0, 0, 2'b00, 0);  // reset out of match over
    add(0, 1, 1, 0, 5'b01000, 0, 0, 2'b00, 0);
    add(0, 1, 1, 0, 5'b10000, 0, 0, 2'b00, 0);
    add(0, 1, 1, 0, 5'b00000, 1, 0, 2'b00, 0);
    add(0, 1, 0, 0, 5'b00000, 1, 0, 2'b00, 0);
    add(1, 1, 0, 0, 5'b00100, 0, 0, 2'b00, 0);  // reset mid-hold
    add(0, 1, 0, 1, 5'b00010, 0, 0, 2'b00, 0);
    add(0, 1, 0, 1, 5'b00001, 0, 0, 2'b00, 0);
    add(0, 1, 0, 1, 5'b00000, 0, 1, 2'b00, 0);
    add(0, 1, 0, 0, 5'b00000, 0, 1, 2'b00, 0);
    add(0, 1, 0, 0, 5'b00000, 0, 1, 2'b00, 0);
    add(0, 1, 0, 0, 5'b00100, 0, 1, 2'b00, 0);
    add(0, 1, 0, 1, 5'b00010, 0, 1, 2'b00, 0);
    add(0, 1, 0, 1, 5'b00001, 0, 1, 2'b00, 0);
    add(0, 1, 0, 1, 5'b00111, 0, 2, 2'b01, 1);  // right wins
    add(0, 1, 1, 0, 5'b00111, 0, 2, 2'b01, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].ce, vecs[i].l, vecs[i].r);
      check($sformatf("vec%0d", i), vecs[i].lights, vecs[i].ls, vecs[i].rs, vecs[i].win,
            vecs[i].mo);
    end

    // CE only every third clock: same sequence as the first scenario, stretched; L held high.
    begin
      logic [4:0] exp_lt [7];
      logic [1:0] exp_ls [7];
      logic [4:0] prev_lt;
      logic [1:0] prev_ls;
      exp_lt = '{5'b01000, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b01000};
      exp_ls = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("slow_reset", 5'b00100, 2'd0, 2'd0, 2'b00, 1'b0);
      prev_lt = 5'b00100;
      prev_ls = 2'd0;
      for (int t = 0; t < 7; t++) begin
        for (int k = 0; k < 3; k++) begin
          step(1'b0, (k == 2), 1'b1, 1'b0);
          if (k == 2) begin
            check($sformatf("slow_t%0d_ce", t), exp_lt[t], exp_ls[t], 2'd0, 2'b00, 1'b0);
          end else begin
            check($sformatf("slow_t%0d_idle%0d", t, k), prev_lt, prev_ls, 2'd0, 2'b00, 1'b0);
          end
        end
        prev_lt = exp_lt[t];
        prev_ls = exp_ls[t];
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
